// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit add/subtract driven through one external 1-bit full adder,
// LSB first, with a start/ready/done handshake around it.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic             fa_a_o,
    output logic             fa_b_o,
    output logic             fa_cin_o,
    input  logic             fa_s_i,
    input  logic             fa_cout_i
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_bit;

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operands are shifted right so the active bit is always at position 0.
    always_comb begin
        ready_o  = (state_q == IDLE);
        done_o   = (state_q == DONE);
        fa_a_o   = (state_q == RUN) ? a_q[0] : 1'b0;
        fa_b_o   = (state_q == RUN) ? b_q[0] : 1'b0;
        fa_cin_o = (state_q == RUN) ? carry_q : 1'b0;
        sum_o    = sum_q;
        cout_o   = cout_q;
        ovf_o    = ovf_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == IDLE && start_i) begin
            a_d     = a_i;
            b_d     = sub_i ? ~b_i : b_i;
            carry_d = sub_i;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_s_i, res_q[WIDTH-1:1]};
            carry_d = fa_cout_i;
            cnt_d   = last_bit ? '0 : cnt_q + CW'(1);
            // On the MSB, carry_q is the carry into the MSB.
            if (last_bit) begin
                sum_d  = res_d;
                cout_d = fa_cout_i;
                ovf_d  = carry_q ^ fa_cout_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer (WIDTH=8) with a behavioural full adder.
module tb_serial_add_sequencer;
    logic       clk = 1'b0;
    logic       rst, start_i, sub_i;
    logic [7:0] a_i, b_i, sum_o;
    logic       ready_o, done_o, cout_o, ovf_o;
    logic       fa_a_o, fa_b_o, fa_cin_o, fa_s_i, fa_cout_i;

    typedef struct packed {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] hold_sum = 8'h00;

    always #5 clk = ~clk;

    assign fa_s_i    = fa_a_o ^ fa_b_o ^ fa_cin_o;
    assign fa_cout_i = (fa_a_o & fa_b_o) | (fa_cin_o & (fa_a_o ^ fa_b_o));

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .sub_i(sub_i),
        .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .done_o(done_o),
        .sum_o(sum_o), .cout_o(cout_o), .ovf_o(ovf_o),
        .fa_a_o(fa_a_o), .fa_b_o(fa_b_o), .fa_cin_o(fa_cin_o),
        .fa_s_i(fa_s_i), .fa_cout_i(fa_cout_i)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic s);
        logic [7:0] bb;
        logic [8:0] r;
        exp_t       e;
        bb     = s ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        e.sum  = r[7:0];
        e.cout = r[8];
        e.ovf  = (a[7] == bb[7]) && (r[7] != a[7]);
        return e;
    endfunction

    // Monitor: scoreboard compare on done, hold/idle checks otherwise.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                hold_sum = 8'h00;
            end else begin
                if (done_o) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 32'(done_o), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sum", 32'(sum_o), 32'(e.sum));
                        check("cout", 32'(cout_o), 32'(e.cout));
                        check("ovf", 32'(ovf_o), 32'(e.ovf));
                        hold_sum = e.sum;
                    end
                end else begin
                    check("sum_hold", 32'(sum_o), 32'(hold_sum));
                end
                if (ready_o || done_o)
                    check("fa_idle", 32'({fa_a_o, fa_b_o, fa_cin_o}), 32'd0);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        while (!ready_o && k < 50) begin
            @(posedge clk); #2;
            k++;
        end
        if (!ready_o) check("ready_timeout", 32'(ready_o), 32'd1);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic s, input exp_t e);
        wait_ready();
        start_i = 1'b1; a_i = a; b_i = b; sub_i = s;
        sb.push_back(e);
        @(posedge clk); #2;
        start_i = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk); #2;
            k++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int   n;
        exp_t e;
        logic [7:0] ra, rb;
        logic rs;
        rst = 1'b0; start_i = 1'b0; sub_i = 1'b0; a_i = 8'h00; b_i = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_sum", 32'(sum_o), 32'd0);
        check("rst_cout_ovf", 32'({cout_o, ovf_o}), 32'd0);
        check("rst_fa", 32'({fa_a_o, fa_b_o, fa_cin_o}), 32'd0);
        rst = 1'b1;

        // 1: basic add with latency and pulse width
        do_op(8'h5A, 8'h3C, 1'b0, '{8'h96, 1'b0, 1'b1});
        n = 0;
        while (!done_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", 32'(n), 32'd9);
        @(negedge clk);
        check("t1_done_width", 32'(done_o), 32'd0);

        // 2, 3: carry out, borrow, overflow
        do_op(8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0});
        do_op(8'h10, 8'h20, 1'b1, '{8'hF0, 1'b0, 1'b0});
        do_op(8'h80, 8'h01, 1'b1, '{8'h7F, 1'b1, 1'b1});

        // 4: start held during RUN/DONE with changing operands
        wait_ready();
        start_i = 1'b1; a_i = 8'h12; b_i = 8'h34; sub_i = 1'b0;
        sb.push_back('{8'h46, 1'b0, 1'b0});
        @(posedge clk); #2;
        a_i = 8'h77; b_i = 8'h11; sub_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("t4_ready_busy", 32'(ready_o), 32'd0);
        end
        sb.push_back('{8'h66, 1'b1, 1'b0});
        @(negedge clk);
        check("t4_ready_back", 32'(ready_o), 32'd1);
        @(posedge clk); #2;
        start_i = 1'b0;
        drain();

        // 5: reset mid-operation at bit 4
        wait_ready();
        start_i = 1'b1; a_i = 8'h33; b_i = 8'h44; sub_i = 1'b0;
        @(posedge clk); #2;
        start_i = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        check("t5_ready", 32'(ready_o), 32'd1);
        check("t5_done", 32'(done_o), 32'd0);
        check("t5_sum", 32'(sum_o), 32'd0);
        check("t5_cout_ovf", 32'({cout_o, ovf_o}), 32'd0);
        repeat (12) @(posedge clk);
        #2;
        do_op(8'h01, 8'h01, 1'b0, '{8'h02, 1'b0, 1'b0});

        // 6: back-to-back random ops
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            e  = model(ra, rb, rs);
            do_op(ra, rb, rs, e);
        end
        drain();
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
